// File: rtl/aux_report_pkg.sv
// ============================================================================
//  Module      : aux_report_pkg
//  Description : Shared constants, UART FSM state encoding and the frame-byte
//                mapping helper for the aux-channel UART reporter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aux_report_pkg;

  localparam logic [7:0] SYNC_BYTE        = 8'hA5;
  localparam int         BASE_FRAME_BYTES = 10;
  // One extra slot reserved for the optional checksum byte.
  localparam int         MAX_FRAME_BYTES  = BASE_FRAME_BYTES + 1;
  localparam int         BYTE_IDX_W       = $clog2(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Maps a byte position within the base frame to its payload.
  function automatic logic [7:0] frame_byte(
    input logic [BYTE_IDX_W-1:0] idx,
    input logic [11:0]           aux0,
    input logic [11:0]           aux1,
    input logic [11:0]           aux2,
    input logic [11:0]           aux3,
    input logic [1:0]            net
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = {4'h0, aux0[11:8]};
      4'd2:    b = aux0[7:0];
      4'd3:    b = {4'h0, aux1[11:8]};
      4'd4:    b = aux1[7:0];
      4'd5:    b = {4'h0, aux2[11:8]};
      4'd6:    b = aux2[7:0];
      4'd7:    b = {4'h0, aux3[11:8]};
      4'd8:    b = aux3[7:0];
      4'd9:    b = {6'h00, net};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aux_uart_reporter_uart_tx_byte.sv
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 UART byte transmitter. A byte is accepted when load is
//                high while ready is high; ready is also raised during the
//                final cycle of the stop bit so bytes can be chained with no
//                idle gap between them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte
  import aux_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int              c_tw         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_tw-1:0] c_timer_last = c_tw'(CLKS_PER_BIT - 1);
  localparam logic [c_tw-1:0] c_timer_one  = c_tw'(1);

  uart_state_t     r_state, w_state_next;
  logic [c_tw-1:0] r_timer, w_timer_next;
  logic [2:0]      r_bitcnt, w_bitcnt_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_tx, w_tx_next;
  logic            w_bit_end;

  assign w_bit_end = (r_timer == c_timer_last);
  assign ready     = (r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end);
  assign tx        = r_tx;

  // State register; the line is held idle-high while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_bitcnt <= w_bitcnt_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
    end
  end

  // Next-state, bit timing and serialisation (LSB first).
  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_bitcnt_next = r_bitcnt;
    w_shift_next  = r_shift;
    w_tx_next     = r_tx;
    case (r_state)
      ST_IDLE: begin
        w_tx_next    = 1'b1;
        w_timer_next = '0;
        if (load) begin
          w_state_next = ST_START;
          w_shift_next = data;
          w_tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next  = ST_DATA;
          w_timer_next  = '0;
          w_bitcnt_next = '0;
          w_tx_next     = r_shift[0];
        end else begin
          w_timer_next = r_timer + c_timer_one;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_timer_next = '0;
          if (r_bitcnt == 3'd7) begin
            w_state_next = ST_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bitcnt_next = r_bitcnt + 3'd1;
            w_shift_next  = {1'b0, r_shift[7:1]};
            w_tx_next     = r_shift[1];
          end
        end else begin
          w_timer_next = r_timer + c_timer_one;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_timer_next = '0;
          if (load) begin
            w_state_next = ST_START;
            w_shift_next = data;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_timer_next = r_timer + c_timer_one;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/aux_uart_reporter.sv
// ============================================================================
//  Module      : aux_uart_reporter
//  Description : Periodically, or on trigger, snapshots the four aux-channel
//                conversions and the network classification and sends them
//                as a framed byte stream over a UART 8N1 line.
//                Optional macro AUX_REPORT_CHECKSUM_EN appends an XOR
//                checksum byte covering every byte after the sync byte.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aux_uart_reporter
  import aux_report_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 868,
  parameter int REPORT_PERIOD = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  network_output,
  input  logic [11:0] MEASURED_AUX0,
  input  logic [11:0] MEASURED_AUX1,
  input  logic [11:0] MEASURED_AUX2,
  input  logic [11:0] MEASURED_AUX3,
  input  logic        trigger,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

`ifdef AUX_REPORT_CHECKSUM_EN
  localparam int c_num_bytes = BASE_FRAME_BYTES + 1;
`else
  localparam int c_num_bytes = BASE_FRAME_BYTES;
`endif

  localparam int                    c_pw          = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  localparam logic [c_pw-1:0]       c_period_last = c_pw'(REPORT_PERIOD - 1);
  localparam logic [c_pw-1:0]       c_period_one  = c_pw'(1);
  localparam logic [BYTE_IDX_W-1:0] c_last_idx    = BYTE_IDX_W'(c_num_bytes - 1);
  localparam logic [BYTE_IDX_W-1:0] c_idx_one     = BYTE_IDX_W'(1);

  logic [c_pw-1:0]       r_period;
  logic                  r_pending;
  logic                  r_active;
  logic                  r_frame_done;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [11:0]           r_aux0, r_aux1, r_aux2, r_aux3;
  logic [1:0]            r_net;

  logic                  w_tick;
  logic                  w_req;
  logic                  w_start;
  logic                  w_last_byte;
  logic                  w_uart_ready;
  logic                  w_advance;
  logic                  w_finish;
  logic                  w_load;
  logic [BYTE_IDX_W-1:0] w_sel_idx;
  logic [7:0]            w_load_byte;

  assign w_tick      = (r_period == c_period_last);
  assign w_req       = w_tick | trigger | r_pending;
  assign w_start     = ~r_active & w_req;
  assign w_last_byte = (r_byte_idx == c_last_idx);
  // The transmitter signals ready only in the final stop-bit cycle while a
  // frame is active, which is exactly when the next byte must be handed over.
  assign w_advance   = r_active & w_uart_ready & ~w_last_byte;
  assign w_finish    = r_active & w_uart_ready & w_last_byte;
  assign w_load      = w_start | w_advance;
  assign w_sel_idx   = w_start ? '0 : (r_byte_idx + c_idx_one);

  assign busy        = r_active;
  assign frame_done  = r_frame_done;

`ifdef AUX_REPORT_CHECKSUM_EN
  logic [7:0] w_checksum;

  // XOR of every payload byte following the sync byte.
  always_comb begin
    w_checksum = 8'h00;
    for (int i = 1; i < BASE_FRAME_BYTES; i++) begin
      w_checksum = w_checksum ^ frame_byte(BYTE_IDX_W'(i), r_aux0, r_aux1, r_aux2, r_aux3, r_net);
    end
  end
`endif

  // Select the byte handed to the transmitter; byte 0 is constant so it is
  // valid even before the snapshot registers update.
  always_comb begin
    w_load_byte = frame_byte(w_sel_idx, r_aux0, r_aux1, r_aux2, r_aux3, r_net);
`ifdef AUX_REPORT_CHECKSUM_EN
    if (w_sel_idx == c_last_idx) begin
      w_load_byte = w_checksum;
    end
`endif
  end

  // Free-running report period counter, independent of frame activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= '0;
    end else if (w_tick) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + c_period_one;
    end
  end

  // Frame sequencing: start/snapshot, one-deep pending request, byte index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active     <= 1'b0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_byte_idx   <= '0;
      r_aux0       <= '0;
      r_aux1       <= '0;
      r_aux2       <= '0;
      r_aux3       <= '0;
      r_net        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_start) begin
        r_active   <= 1'b1;
        r_pending  <= 1'b0;
        r_byte_idx <= '0;
        r_aux0     <= MEASURED_AUX0;
        r_aux1     <= MEASURED_AUX1;
        r_aux2     <= MEASURED_AUX2;
        r_aux3     <= MEASURED_AUX3;
        r_net      <= network_output;
      end else begin
        if (r_active & (w_tick | trigger)) begin
          r_pending <= 1'b1;
        end
        if (w_advance) begin
          r_byte_idx <= r_byte_idx + c_idx_one;
        end
        if (w_finish) begin
          r_active     <= 1'b0;
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .data  (w_load_byte),
    .ready (w_uart_ready),
    .tx    (tx)
  );

endmodule

`default_nettype wire

// File: tb/tb_aux_uart_reporter.sv
// ============================================================================
//  Module      : tb_aux_uart_reporter
//  Description : Scoreboard bench for aux_uart_reporter. Expected bytes,
//                frame_done cycles and busy widths are queued when a frame
//                request is driven and compared as the UART line is decoded.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aux_uart_reporter;

  localparam int B  = 4;
  localparam int RP = 1000;
  localparam int HB = B / 2;
`ifdef AUX_REPORT_CHECKSUM_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * 10 * B;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic [1:0]  net = 2'd0;
  logic [11:0] aux0 = '0, aux1 = '0, aux2 = '0, aux3 = '0;
  logic        tx, busy, frame_done;

  exp_t sb[$];
  int   done_q[$];
  int   width_q[$];
  int   cyc;
  int   n_checks = 0;
  int   n_fail   = 0;

  aux_uart_reporter #(
    .CLKS_PER_BIT  (B),
    .REPORT_PERIOD (RP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .network_output (net),
    .MEASURED_AUX0  (aux0),
    .MEASURED_AUX1  (aux1),
    .MEASURED_AUX2  (aux2),
    .MEASURED_AUX3  (aux3),
    .trigger        (trigger),
    .tx             (tx),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  // Cycle index equals the DUT period counter value after reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input int t);
    logic [7:0] bytes [NB];
    exp_t       e;
    bytes[0] = 8'hA5;
    bytes[1] = {4'h0, aux0[11:8]};
    bytes[2] = aux0[7:0];
    bytes[3] = {4'h0, aux1[11:8]};
    bytes[4] = aux1[7:0];
    bytes[5] = {4'h0, aux2[11:8]};
    bytes[6] = aux2[7:0];
    bytes[7] = {4'h0, aux3[11:8]};
    bytes[8] = aux3[7:0];
    bytes[9] = {6'h00, net};
`ifdef AUX_REPORT_CHECKSUM_EN
    bytes[10] = 8'h00;
    for (int i = 1; i < 10; i++) bytes[10] = bytes[10] ^ bytes[i];
`endif
    for (int i = 0; i < NB; i++) begin
      e.b     = bytes[i];
      e.start = (i == 0) ? t + 1 : -1;
      sb.push_back(e);
    end
    done_q.push_back(t + FRAME + 1);
    width_q.push_back(FRAME);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_trigger(input int n, input bit expect_frame);
    wait_cyc(n);
    trigger = 1'b1;
    if (expect_frame) push_frame(n);
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // UART line decoder: samples mid-bit and scores each received byte.
  initial begin
    bit         active = 0;
    int         cnt = 0;
    int         start_cyc = 0;
    logic [7:0] rx = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else if (!active) begin
        if (tx == 1'b0) begin
          active    = 1;
          cnt       = 0;
          start_cyc = cyc;
        end
      end else begin
        cnt++;
        if (cnt == HB) begin
          check("start_bit", {31'd0, tx}, 32'd0);
        end else if (cnt > HB && cnt < 9 * B && (cnt % B) == HB) begin
          rx = {tx, rx[7:1]};
        end else if (cnt == 9 * B + HB) begin
          check("stop_bit", {31'd0, tx}, 32'd1);
          check("sb_avail", {31'd0, sb.size() > 0}, 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("byte", {24'd0, rx}, {24'd0, e.b});
            if (e.start >= 0) check("frame_start_cyc", start_cyc, e.start);
          end
        end
        if (cnt == 10 * B - 1) active = 0;
      end
    end
  end

  // busy width and frame_done timing monitor.
  initial begin
    bit prev = 0;
    int rise = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 0;
      end else begin
        if (busy && !prev) rise = cyc;
        if (!busy && prev) begin
          check("width_avail", {31'd0, width_q.size() > 0}, 32'd1);
          if (width_q.size() > 0) check("busy_width", cyc - rise, width_q.pop_front());
        end
        if (frame_done) begin
          check("done_avail", {31'd0, done_q.size() > 0}, 32'd1);
          if (done_q.size() > 0) check("frame_done_cyc", cyc, done_q.pop_front());
        end
        prev = busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus sequence.
  initial begin
    aux0 = 12'hABC;
    aux1 = 12'h123;
    aux2 = 12'h000;
    aux3 = 12'hFFF;
    net  = 2'd2;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Triggered frame; then a tick coinciding with a trigger gives one frame.
    pulse_trigger(10, 1'b1);
    pulse_trigger(RP - 1, 1'b1);
    // Input change mid-frame must not affect the frame in flight.
    wait_cyc(RP + 100);
    aux1 = 12'h456;
    // Periodic frame; two triggers during it yield exactly one extra frame.
    wait_cyc(2 * RP - 1);
    push_frame(2 * RP - 1);
    pulse_trigger(2 * RP + 100, 1'b0);
    pulse_trigger(2 * RP + 200, 1'b0);
    wait_cyc(2 * RP + 300);
    net = 2'd1;
    wait_cyc(2 * RP - 1 + FRAME + 1);
    push_frame(2 * RP - 1 + FRAME + 1);
    wait_cyc(3 * RP - 1);
    push_frame(3 * RP - 1);

    // Reset in the middle of byte 4 aborts the frame at once.
    pulse_trigger(3500, 1'b1);
    wait_cyc(3500 + 1 + 4 * 10 * B + 3 * B);
    #1 rst = 1'b1;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    done_q.delete();
    width_q.delete();
    repeat (5) @(negedge clk);
    check("abort_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    wait_cyc(5);
    check("post_rst_tx", {31'd0, tx}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    pulse_trigger(20, 1'b1);
    wait_cyc(20 + FRAME + 20);

    check("sb_drained", sb.size(), 32'd0);
    check("done_drained", done_q.size(), 32'd0);
    check("width_drained", width_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
